axil_slave_regbank: RTL

AXI4-Lite slave register bank: the responder end of the AXI4-Lite link the `chip` testbench master VIP drives. It accepts single-beat reads and writes from the `chip` AXI4-Lite interconnect and holds NUM_REGS 32-bit control registers. It drives the register contents to the fabric as a flat vector and returns OKAY/SLVERR responses.

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_regbank_wr_ctrl.sv | 84 ++++++++
 rtl/axil_slave_regbank.sv | 105 ++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, widths and FSM state types.
// Define AXIL_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
package axil_pkg;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam resp_t RESP_OOR = RESP_SLVERR;
`else
    localparam resp_t RESP_OOR = RESP_OKAY;
`endif
    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
endpackage

// File: rtl/axil_regbank_wr_ctrl.sv
// axil_regbank_wr_ctrl: latches AW and W independently, then issues a one-cycle register write and the B response.
module axil_regbank_wr_ctrl
    import axil_pkg::*;
#(
    parameter int IDX_W    = 6,
    parameter int NUM_REGS = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IDX_W-1:0]       awidx_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [AXIL_DATA_W-1:0] wdata_i,
    input  logic [AXIL_STRB_W-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output resp_t                  bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    output logic                   we_o,
    output logic [IDX_W-1:0]       widx_o,
    output logic [AXIL_DATA_W-1:0] wdata_o,
    output logic [AXIL_STRB_W-1:0] wstrb_o
);
    wr_state_t state_q, state_d;
    logic aw_q, aw_d, w_q, w_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [AXIL_DATA_W-1:0] data_q, data_d;
    logic [AXIL_STRB_W-1:0] strb_q, strb_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    resp_t bresp_q, bresp_d;
    logic aw_hs, w_hs, commit, done, in_range;
    always_comb begin
        aw_hs     = awvalid_i && awready_q;
        w_hs      = wvalid_i && wready_q;
        in_range  = int'(idx_q) < NUM_REGS;
        commit    = state_q == WR_IDLE && aw_q && w_q;
        done      = state_q == WR_RESP && bready_i;
        state_d   = commit ? WR_RESP : done ? WR_IDLE : state_q;
        aw_d      = !done && (aw_q || aw_hs);
        w_d       = !done && (w_q || w_hs);
        idx_d     = aw_hs ? awidx_i : idx_q;
        data_d    = w_hs ? wdata_i : data_q;
        strb_d    = w_hs ? wstrb_i : strb_q;
        // readies are computed from next state so they are registered yet never accept into a full latch
        awready_d = state_d == WR_IDLE && !aw_d;
        wready_d  = state_d == WR_IDLE && !w_d;
        bvalid_d  = state_d == WR_RESP;
        bresp_d   = commit ? (in_range ? RESP_OKAY : RESP_OOR) : bresp_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= WR_IDLE;
            aw_q      <= 1'b0;
            w_q       <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_q      <= aw_d;
            w_q       <= w_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign we_o      = commit && in_range;
    assign widx_o    = idx_q;
    assign wdata_o   = data_q;
    assign wstrb_o   = strb_q;
endmodule

// File: rtl/axil_slave_regbank.sv
// axil_slave_regbank: AXI4-Lite slave holding NUM_REGS 32-bit control registers exported on reg_out.
// Out-of-range response code follows AXIL_REGBANK_SLVERR_EN (see axil_pkg).
module axil_slave_regbank
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [AXIL_DATA_W-1:0]          s_axil_wdata,
    input  logic [AXIL_STRB_W-1:0]          s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [AXIL_DATA_W-1:0]          s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [NUM_REGS*AXIL_DATA_W-1:0] reg_out
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    logic we;
    logic [IDX_W-1:0] widx, ridx;
    logic [AXIL_DATA_W-1:0] wdata, rd_word;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];
    rd_state_t rd_q, rd_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d, ar_hs;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
    resp_t rresp_q, rresp_d;
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};
    axil_regbank_wr_ctrl #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_wr_ctrl (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .awidx_i   (s_axil_awaddr[ADDR_WIDTH-1:2]),
        .awvalid_i (s_axil_awvalid),
        .awready_o (s_axil_awready),
        .wdata_i   (s_axil_wdata),
        .wstrb_i   (s_axil_wstrb),
        .wvalid_i  (s_axil_wvalid),
        .wready_o  (s_axil_wready),
        .bresp_o   (s_axil_bresp),
        .bvalid_o  (s_axil_bvalid),
        .bready_i  (s_axil_bready),
        .we_o      (we),
        .widx_o    (widx),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb)
    );
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < AXIL_STRB_W; k++)
                    if (we && widx == IDX_W'(i) && wstrb[k]) regs_q[i][8*k +: 8] <= wdata[8*k +: 8];
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*AXIL_DATA_W +: AXIL_DATA_W] = regs_q[g];
    end
    always_comb begin
        ridx    = s_axil_araddr[ADDR_WIDTH-1:2];
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ridx == IDX_W'(i)) rd_word = regs_q[i];
        ar_hs     = s_axil_arvalid && arready_q;
        rd_d      = ar_hs ? RD_DATA : (rd_q == RD_DATA && s_axil_rready) ? RD_IDLE : rd_q;
        arready_d = rd_d == RD_IDLE;
        rvalid_d  = rd_d == RD_DATA;
        rdata_d   = ar_hs ? rd_word : rdata_q;
        rresp_d   = ar_hs ? (int'(ridx) < NUM_REGS ? RESP_OKAY : RESP_OOR) : rresp_q;
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_q      <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rd_q      <= rd_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
endmodule
